// File: rtl/bw_bbox_tracker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | obj_det_pkg : shared frame geometry, BW pixel value, tracker states  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package obj_det_pkg;

  localparam int DEF_FRAME_W    = 320;
  localparam int DEF_FRAME_H    = 240;
  localparam int DEF_MIN_PIXELS = 64;
  localparam int DEF_X_W        = $clog2(DEF_FRAME_W);
  localparam int DEF_Y_W        = $clog2(DEF_FRAME_H);
  localparam int DEF_CNT_W      = $clog2(DEF_FRAME_W * DEF_FRAME_H + 1);

  localparam logic [7:0] BW_OBJ = 8'd255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/bw_bbox_tracker_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bw_bbox_tracker_if : pixel stream in, frame result out               |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface bw_bbox_tracker_if
  import obj_det_pkg::*;
#(
  parameter int X_W   = DEF_X_W,
  parameter int Y_W   = DEF_Y_W,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic [7:0]       pix_in;
  logic             pix_valid;
  logic             pix_sof;
  logic             pix_ready;
  logic             res_valid;
  logic             obj_found;
  logic [CNT_W-1:0] obj_count;
  logic [X_W-1:0]   x_min;
  logic [X_W-1:0]   x_max;
  logic [Y_W-1:0]   y_min;
  logic [Y_W-1:0]   y_max;

  modport master (
    output pix_in, pix_valid, pix_sof,
    input  pix_ready, res_valid, obj_found, obj_count, x_min, x_max, y_min, y_max
  );

  modport slave (
    input  pix_in, pix_valid, pix_sof,
    output pix_ready, res_valid, obj_found, obj_count, x_min, x_max, y_min, y_max
  );

endinterface
`default_nettype wire

// File: rtl/bw_bbox_tracker_raster_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | raster_counter : col/row position with sof restart and frame-end flag|
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module raster_counter #(
  parameter int FRAME_W = 320,
  parameter int FRAME_H = 240,
  parameter int X_W     = 9,
  parameter int Y_W     = 8
) (
  input  wire logic           clk,
  input  wire logic           resetn,
  input  wire logic           en_i,
  input  wire logic           sof_i,
  output logic [X_W-1:0]      col_o,
  output logic [Y_W-1:0]      row_o,
  output logic                eof_o
);

  logic [X_W-1:0] col_q, col_d;
  logic [Y_W-1:0] row_q, row_d;
  logic           w_col_last;
  logic           w_row_last;

  // sof forces the current pixel to (0,0) regardless of where the count was
  assign col_o      = sof_i ? '0 : col_q;
  assign row_o      = sof_i ? '0 : row_q;
  assign w_col_last = (col_o == X_W'(FRAME_W - 1));
  assign w_row_last = (row_o == Y_W'(FRAME_H - 1));
  assign eof_o      = w_col_last && w_row_last;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (en_i) begin
      if (w_col_last) begin
        col_d = '0;
        row_d = w_row_last ? '0 : row_o + 1'b1;
      end else begin
        col_d = col_o + 1'b1;
        row_d = row_o;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bw_bbox_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bw_bbox_tracker : per-frame bounding box and object-pixel count      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bw_bbox_tracker
  import obj_det_pkg::*;
#(
  parameter int FRAME_W    = DEF_FRAME_W,
  parameter int FRAME_H    = DEF_FRAME_H,
  parameter int MIN_PIXELS = DEF_MIN_PIXELS,
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  bw_bbox_tracker_if.slave  bus
);

  state_e           state_q, state_d;
  logic             w_ready, w_beat, w_proc, w_obj, w_eof, w_frame_end;
  logic [X_W-1:0]   w_col;
  logic [Y_W-1:0]   w_row;
  logic [CNT_W-1:0] w_base_cnt;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [X_W-1:0]   xmin_q, xmin_d, xmax_q, xmax_d;
  logic [Y_W-1:0]   ymin_q, ymin_d, ymax_q, ymax_d;

  logic             res_found_q;
  logic [CNT_W-1:0] res_cnt_q;
  logic [X_W-1:0]   res_xmin_q, res_xmax_q;
  logic [Y_W-1:0]   res_ymin_q, res_ymax_q;

  assign w_ready     = (state_q != REPORT);
  assign w_beat      = bus.pix_valid && w_ready;
  // non-sof beats in IDLE are consumed but ignored
  assign w_proc      = w_beat && (bus.pix_sof || (state_q == SCAN));
  assign w_obj       = (bus.pix_in == BW_OBJ);
  assign w_frame_end = w_proc && w_eof;

  raster_counter #(
    .FRAME_W (FRAME_W),
    .FRAME_H (FRAME_H),
    .X_W     (X_W),
    .Y_W     (Y_W)
  ) u_raster (
    .clk    (clk),
    .resetn (resetn),
    .en_i   (w_proc),
    .sof_i  (bus.pix_sof),
    .col_o  (w_col),
    .row_o  (w_row),
    .eof_o  (w_eof)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_proc) state_d = w_frame_end ? REPORT : SCAN;
      SCAN:    if (w_frame_end) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // a sof beat restarts the frame, so the old count is ignored for that pixel
  assign w_base_cnt = bus.pix_sof ? '0 : cnt_q;

  always_comb begin
    cnt_d  = cnt_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    if (w_proc) begin
      cnt_d = w_base_cnt + CNT_W'(w_obj);
      if (w_obj) begin
        if (w_base_cnt == '0) begin
          xmin_d = w_col;
          xmax_d = w_col;
          ymin_d = w_row;
          ymax_d = w_row;
        end else begin
          if (w_col < xmin_q) xmin_d = w_col;
          if (w_col > xmax_q) xmax_d = w_col;
          if (w_row < ymin_q) ymin_d = w_row;
          if (w_row > ymax_q) ymax_d = w_row;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
    end
  end

  // results load on the last beat so they are valid alongside the REPORT pulse
  always_ff @(posedge clk) begin
    if (!resetn) begin
      res_found_q <= 1'b0;
      res_cnt_q   <= '0;
      res_xmin_q  <= '0;
      res_xmax_q  <= '0;
      res_ymin_q  <= '0;
      res_ymax_q  <= '0;
    end else if (w_frame_end) begin
      res_found_q <= (cnt_d >= CNT_W'(MIN_PIXELS));
      res_cnt_q   <= cnt_d;
      res_xmin_q  <= (cnt_d == '0) ? '0 : xmin_d;
      res_xmax_q  <= (cnt_d == '0) ? '0 : xmax_d;
      res_ymin_q  <= (cnt_d == '0) ? '0 : ymin_d;
      res_ymax_q  <= (cnt_d == '0) ? '0 : ymax_d;
    end
  end

  assign bus.pix_ready = w_ready;
  assign bus.res_valid = (state_q == REPORT);
  assign bus.obj_found = res_found_q;
  assign bus.obj_count = res_cnt_q;
  assign bus.x_min     = res_xmin_q;
  assign bus.x_max     = res_xmax_q;
  assign bus.y_min     = res_ymin_q;
  assign bus.y_max     = res_ymax_q;

endmodule
`default_nettype wire
